dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory (DMEM) between the core's load/store port (m0) and a program-loader/debug master (m1). It issues at most one access per cycle and routes each one-cycle-latency response back to the port that issued it. Port m1 can lock the memory for burst loads, with a bounded hold time so the core is never starved. It sits between the core's data port, the loader and the DMEM instance.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter_rr_arb2.sv | 28 ++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMEM arbiter: FSM state, port identifiers and the
// pending-response tag.
package dmem_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } port_id_t;

   // One outstanding response at most: the memory has one-cycle read latency
   typedef struct packed {
      logic     valid;
      port_id_t port;
      logic     is_read;
   } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way request picker. A lone requester always wins; on a conflict the
// port that was not granted last wins. Driving last with a constant M1 turns
// this into fixed m0-first priority, which is how the top builds it when
// round-robin is not configured.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic     valid0,
   input  logic     valid1,
   input  port_id_t last,
   output logic     gnt0,
   output logic     gnt1
);

   // Resolve the grant from the two requests and the last winner
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (valid0 && valid1) begin
         if (last == M1) gnt0 = 1'b1;
         else            gnt1 = 1'b1;
      end else begin
         gnt0 = valid0;
         gnt1 = valid1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the core load/store port (m0) and the
// loader/debug master (m1). One access per cycle, one-cycle response routed
// back to the issuing port, and a bounded exclusive lock for m1.
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution;
// without it m0 always wins conflicts and no pointer register exists.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_req_valid,
   output logic                m0_req_ready,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W/8-1:0] m0_we,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_rsp_valid,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_req_valid,
   output logic                m1_req_ready,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W/8-1:0] m1_we,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_rsp_valid,
   output logic [DATA_W-1:0]   m1_rdata,
   input  logic                m1_lock,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

   arb_state_t       state;
   logic [CNT_W-1:0] lock_cnt;
   logic             force_m0;    // first ARB cycle after a forced break
   logic             lock_block;  // lock refused until m1_lock drops once
   port_id_t         last;
   rsp_tag_t         tag;
   logic             pick0, pick1;
   logic             gnt0, gnt1;

   rr_arb2 u_pick (
      .valid0 (m0_req_valid),
      .valid1 (m1_req_valid),
      .last   (last),
      .gnt0   (pick0),
      .gnt1   (pick1)
   );

   // Final grant: lock ownership and forced-break priority override the picker
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == LOCK) begin
         gnt1 = m1_req_valid;
      end else if (force_m0 && m0_req_valid) begin
         gnt0 = 1'b1;
      end else begin
         gnt0 = pick0;
         gnt1 = pick1;
      end
   end

   assign m0_req_ready = gnt0;
   assign m1_req_ready = gnt1;

   // Steer the winner onto the memory port; idle cycles drive zeros
   always_comb begin
      mem_en    = gnt0 | gnt1;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt0) begin
         mem_we    = m0_we;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
      end else if (gnt1) begin
         mem_we    = m1_we;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Remember the last granted port; reset value makes m0 win the first conflict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last <= M1;
      else if (gnt0) last <= M0;
      else if (gnt1) last <= M1;
   end
`else
   assign last = M1;
`endif

   // Lock FSM: entry on a locked m1 grant, exit on release or hold-time limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         lock_cnt   <= '0;
         force_m0   <= 1'b0;
         lock_block <= 1'b0;
      end else begin
         case (state)
            ARB: begin
               force_m0 <= 1'b0;
               lock_cnt <= '0;
               if (gnt1 && m1_lock && !lock_block) state <= LOCK;
            end
            LOCK: begin
               if (lock_cnt == CNT_LAST) begin
                  state    <= ARB;
                  lock_cnt <= '0;
                  force_m0 <= 1'b1;
               end else if (!m1_lock) begin
                  state    <= ARB;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            default: state <= ARB;
         endcase
         if (!m1_lock)
            lock_block <= 1'b0;
         else if (state == LOCK && lock_cnt == CNT_LAST)
            lock_block <= 1'b1;
      end
   end

   // Record who issued this cycle's access so the response goes back to it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag <= '0;
      end else begin
         tag.valid   <= gnt0 | gnt1;
         tag.port    <= gnt1 ? M1 : M0;
         tag.is_read <= gnt0 ? (m0_we == '0) : (m1_we == '0);
      end
   end

   assign m0_rsp_valid = tag.valid && (tag.port == M0);
   assign m1_rsp_valid = tag.valid && (tag.port == M1);
   assign m0_rdata     = (m0_rsp_valid && tag.is_read) ? mem_rdata : '0;
   assign m1_rdata     = (m1_rsp_valid && tag.is_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-with-pending sequence
// and randomized traffic against a behavioural model of the arbiter rules.
module tb_dmem_arbiter;

   localparam int MAX_LOCK = 4;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic        v0;
      logic [3:0]  we0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        v1;
      logic [3:0]  we1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        lk;
   } in_t;

   typedef struct {
      in_t in;
      bit  r0;
      bit  r1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req_valid, m0_req_ready, m0_rsp_valid;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_we;
   logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_lock;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_we;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit          md_locked, md_force, md_block, md_last;
   int          md_n;
   bit          ex_rv0, ex_rv1;
   logic [31:0] ex_rd;
   logic [31:0] smem [16];

   // bench-side memory
   logic        load;
   logic [31:0] bmem [16];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
      .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
      .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
      .m1_lock(m1_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] pattern(input int i);
      return (i == 0) ? 32'h0000_000A : 32'h1000_0000 + 32'(i) * 32'h111;
   endfunction

   // Single-port memory with one-cycle read latency
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 16; i++) bmem[i] <= pattern(i);
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we == 4'h0) mem_rdata <= bmem[mem_addr[5:2]];
         else
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) bmem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input in_t x);
      m0_req_valid = x.v0; m0_we = x.we0; m0_addr = x.a0; m0_wdata = x.d0;
      m1_req_valid = x.v1; m1_we = x.we1; m1_addr = x.a1; m1_wdata = x.d1;
      m1_lock = x.lk;
   endtask

   task automatic model_reset();
      md_locked = 0; md_force = 0; md_block = 0; md_last = 1; md_n = 0;
      ex_rv0 = 0; ex_rv1 = 0; ex_rd = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready0"}, m0_req_ready, 0);
      chk({tag, "_ready1"}, m1_req_ready, 0);
      chk({tag, "_rsp0"},   m0_rsp_valid, 0);
      chk({tag, "_rsp1"},   m1_rsp_valid, 0);
      chk({tag, "_rdata0"}, m0_rdata, 0);
      chk({tag, "_rdata1"}, m1_rdata, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   // One clock cycle: called just after a falling edge, returns there
   task automatic step(input in_t x, output bit r0, output bit r1);
      bit g0, g1, forced;
      logic [3:0] we;
      logic [31:0] a, d;
      int idx;
      drive(x);
      #2;
      g0 = 0; g1 = 0;
      if (md_locked)              g1 = x.v1;
      else if (md_force && x.v0)  g0 = 1;
      else if (x.v0 && x.v1) begin
         if (RR && !md_last) g1 = 1;
         else                g0 = 1;
      end else begin
         g0 = x.v0; g1 = x.v1;
      end
      we = g0 ? x.we0 : (g1 ? x.we1 : 4'h0);
      a  = g0 ? x.a0 : x.a1;
      d  = g0 ? x.d0 : x.d1;
      chk("m0_req_ready", m0_req_ready, g0);
      chk("m1_req_ready", m1_req_ready, g1);
      chk("mem_en", mem_en, g0 | g1);
      chk("mem_we", mem_we, we);
      if (g0 | g1) begin
         chk("mem_addr", mem_addr, a);
         chk("mem_wdata", mem_wdata, d);
      end
      chk("m0_rsp_valid", m0_rsp_valid, ex_rv0);
      chk("m1_rsp_valid", m1_rsp_valid, ex_rv1);
      if (ex_rv0) chk("m0_rdata", m0_rdata, ex_rd);
      if (ex_rv1) chk("m1_rdata", m1_rdata, ex_rd);
      r0 = m0_req_ready;
      r1 = m1_req_ready;
      @(posedge clk);
      ex_rv0 = g0; ex_rv1 = g1; ex_rd = '0;
      if (g0 | g1) begin
         md_last = g1;
         idx = int'(a[5:2]);
         if (we == 4'h0) ex_rd = smem[idx];
         else
            for (int b = 0; b < 4; b++)
               if (we[b]) smem[idx][8*b +: 8] = d[8*b +: 8];
      end
      forced = 0;
      if (!md_locked) begin
         md_force = 0;
         if (g1 && x.lk && !md_block) begin md_locked = 1; md_n = 0; end
      end else begin
         md_n++;
         if (md_n == MAX_LOCK) begin
            md_locked = 0; md_force = 1; forced = 1;
         end else if (!x.lk) md_locked = 0;
      end
      if (!x.lk)       md_block = 0;
      else if (forced) md_block = 1;
      @(negedge clk);
   endtask

   function automatic vec_t mk(bit v0, logic [3:0] we0, logic [31:0] a0, logic [31:0] d0,
                               bit v1, logic [3:0] we1, logic [31:0] a1, logic [31:0] d1,
                               bit lk, bit r0, bit r1);
      vec_t v;
      v.in = '{v0: v0, we0: we0, a0: a0, d0: d0, v1: v1, we1: we1, a1: a1, d1: d1, lk: lk};
      v.r0 = r0;
      v.r1 = r1;
      return v;
   endfunction

   initial begin
      vec_t tbl [27];
      in_t  idle, cur;
      bit   r0, r1, hold0, hold1;

      idle = '0;
      tbl[0]  = mk(1,0,0,0,      0,0,0,0,     0, 1,0);      // single read
      tbl[1]  = mk(0,0,0,0,      1,0,4,0,     0, 0,1);
      tbl[2]  = mk(1,0,0,0,      1,0,4,0,     0, 1,0);      // conflicts
      tbl[3]  = mk(1,0,0,0,      1,0,4,0,     0, !RR,RR);
      tbl[4]  = mk(1,0,0,0,      1,0,4,0,     0, 1,0);
      tbl[5]  = mk(1,0,0,0,      1,0,4,0,     0, !RR,RR);
      tbl[6]  = mk(1,4'hF,8,32'hA, 0,0,0,0,   0, 1,0);      // write response
      tbl[7]  = mk(0,0,0,0,      0,0,0,0,     0, 0,0);
      tbl[8]  = mk(0,0,0,0,      1,4'hF,4,5,  1, 0,1);      // lock entry
      tbl[9]  = mk(1,0,0,0,      1,4'hF,4,5,  1, 0,1);
      tbl[10] = mk(1,0,0,0,      1,4'hF,4,5,  0, 0,1);      // release
      tbl[11] = mk(1,0,0,0,      1,0,4,0,     0, 1,0);
      tbl[12] = mk(0,0,0,0,      0,0,0,0,     0, 0,0);
      tbl[13] = mk(0,0,0,0,      1,0,12,0,    1, 0,1);      // forced break
      tbl[14] = mk(1,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[15] = mk(1,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[16] = mk(1,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[17] = mk(1,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[18] = mk(1,0,0,0,      1,0,12,0,    1, 1,0);
      tbl[19] = mk(0,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[20] = mk(0,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[21] = mk(1,0,0,0,      1,0,12,0,    1, 1,0);
      tbl[22] = mk(0,0,0,0,      1,0,12,0,    0, 0,1);
      tbl[23] = mk(0,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[24] = mk(1,0,0,0,      1,0,12,0,    1, 0,1);
      tbl[25] = mk(0,0,0,0,      0,0,0,0,     0, 0,0);
      tbl[26] = mk(0,0,0,0,      0,0,0,0,     0, 0,0);

      for (int i = 0; i < 16; i++) smem[i] = pattern(i);
      model_reset();
      drive(idle);
      rst_n = 1'b0;
      load  = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      load  = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].in, r0, r1);
         chk($sformatf("vec%0d_ready0", i), r0, tbl[i].r0);
         chk($sformatf("vec%0d_ready1", i), r1, tbl[i].r1);
      end

      // reset while a read response is pending
      cur = idle; cur.v0 = 1; cur.a0 = 32'h4;
      step(cur, r0, r1);
      drive(idle);
      rst_n = 1'b0;
      #2;
      chk_all_zero("midreset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(idle, r0, r1);

      // randomized traffic
      cur = idle;
      hold0 = 0;
      hold1 = 0;
      for (int c = 0; c < 600; c++) begin
         if (!hold0) begin
            cur.v0  = ($urandom_range(0, 9) < 6);
            cur.we0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            cur.a0  = 32'($urandom_range(0, 15)) << 2;
            cur.d0  = $urandom;
         end
         if (!hold1) begin
            cur.v1  = ($urandom_range(0, 9) < 6);
            cur.we1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            cur.a1  = 32'($urandom_range(0, 15)) << 2;
            cur.d1  = $urandom;
         end
         if ($urandom_range(0, 4) == 0) cur.lk = ~cur.lk;
         step(cur, r0, r1);
         hold0 = cur.v0 && !r0;
         hold1 = cur.v1 && !r1;
      end

      step(idle, r0, r1);
      step(idle, r0, r1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
